// File: rtl/hazard_scoreboard.sv
// Operand forwarding select plus per-register countdown scoreboard for EX-stage hazards.
// Optional `HAZARD_STALL_CNT_EN adds a saturating stall_cycles counter output.
module hazard_scoreboard #(
  parameter int NUM_SRC    = 2,
  parameter int REG_ADDR_W = 5,
  parameter int MAX_LAT    = 7,
  parameter int CNT_W      = $clog2(MAX_LAT + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0]         mem_rd,
  input  logic [REG_ADDR_W-1:0]         wb_rd,
  input  logic                          mem_reg_wr,
  input  logic                          wb_reg_wr,
  input  logic                          issue_valid,
  input  logic [REG_ADDR_W-1:0]         issue_rd,
  input  logic                          issue_reg_wr,
  input  logic [CNT_W-1:0]              issue_lat,
  output logic [NUM_SRC*2-1:0]          forward,
  output logic                          stall,
  output logic                          sb_busy
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]                   stall_cycles
`endif
);

  localparam int unsigned NUM_REGS = 1 << REG_ADDR_W;
  localparam logic [CNT_W-1:0] MAX_LAT_C = CNT_W'(MAX_LAT);

  // Register 0 is hardwired zero, so it has no counter.
  logic [CNT_W-1:0] cnt [1:NUM_REGS-1];
  logic             accept;
  logic [CNT_W-1:0] lat_sat;

  assign accept  = issue_valid && !stall;
  assign lat_sat = (issue_lat > MAX_LAT_C) ? MAX_LAT_C : issue_lat;

  always_comb begin
    forward = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (mem_reg_wr && mem_rd != '0 && mem_rd == ex_rs[i*REG_ADDR_W +: REG_ADDR_W])
        forward[2*i +: 2] = 2'b10;
      else if (wb_reg_wr && wb_rd != '0 && wb_rd == ex_rs[i*REG_ADDR_W +: REG_ADDR_W])
        forward[2*i +: 2] = 2'b01;
    end
  end

  // Lookup via compare loop keeps operand address 0 from indexing a missing counter.
  always_comb begin
    stall = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        if (ex_rs[i*REG_ADDR_W +: REG_ADDR_W] == REG_ADDR_W'(r) && cnt[r] != '0)
          stall = 1'b1;
      end
    end
  end

  always_comb begin
    sb_busy = 1'b0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      if (cnt[r] != '0)
        sb_busy = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 1; r < NUM_REGS; r++)
        cnt[r] <= '0;
    end else begin
      for (int unsigned r = 1; r < NUM_REGS; r++) begin
        if (accept && issue_reg_wr && issue_rd == REG_ADDR_W'(r) && issue_lat != '0)
          cnt[r] <= lat_sat;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - 1'b1;
      end
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (stall && stall_cycles != '1)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (MAX_LAT=5 so saturation is observable).
module tb_hazard_scoreboard;

  localparam int NUM_SRC    = 2;
  localparam int REG_ADDR_W = 5;
  localparam int MAX_LAT    = 5;
  localparam int CNT_W      = $clog2(MAX_LAT + 1);

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic [NUM_SRC*REG_ADDR_W-1:0] ex_rs;
  logic [REG_ADDR_W-1:0]         mem_rd, wb_rd, issue_rd;
  logic                          mem_reg_wr, wb_reg_wr, issue_valid, issue_reg_wr;
  logic [CNT_W-1:0]              issue_lat;
  logic [NUM_SRC*2-1:0]          forward;
  logic                          stall, sb_busy;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0]                   stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  hazard_scoreboard #(
    .NUM_SRC(NUM_SRC), .REG_ADDR_W(REG_ADDR_W), .MAX_LAT(MAX_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ex_rs(ex_rs), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_reg_wr(mem_reg_wr), .wb_reg_wr(wb_reg_wr), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .issue_reg_wr(issue_reg_wr), .issue_lat(issue_lat),
    .forward(forward), .stall(stall), .sb_busy(sb_busy)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rs(input logic [REG_ADDR_W-1:0] rs1, input logic [REG_ADDR_W-1:0] rs0);
    ex_rs = {rs1, rs0};
  endtask

  task automatic issue(input logic [REG_ADDR_W-1:0] rd, input logic [CNT_W-1:0] lat);
    issue_valid = 1'b1; issue_reg_wr = 1'b1; issue_rd = rd; issue_lat = lat;
  endtask

  task automatic no_issue();
    issue_valid = 1'b0; issue_reg_wr = 1'b0; issue_rd = '0; issue_lat = '0;
  endtask

  initial begin
    rst_n = 1'b0; ex_rs = '0; mem_rd = '0; wb_rd = '0;
    mem_reg_wr = 1'b0; wb_reg_wr = 1'b0;
    no_issue();
    repeat (2) tick();
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Reset state, no writers
    set_rs(5'd2, 5'd1); #1;
    check("rst_fwd", 32'(forward), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_busy", 32'(sb_busy), 32'h0);
`ifdef HAZARD_STALL_CNT_EN
    check("rst_scnt", stall_cycles, 32'h0);
`endif

    // Forwarding priority
    mem_rd = 5'd5; wb_rd = 5'd5; mem_reg_wr = 1'b1; wb_reg_wr = 1'b1;
    set_rs(5'd5, 5'd5); #1;
    check("fwd_mem", 32'(forward), 32'b1010);
    mem_reg_wr = 1'b0; #1;
    check("fwd_wb", 32'(forward), 32'b0101);
    mem_reg_wr = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0; set_rs(5'd0, 5'd0); #1;
    check("fwd_r0", 32'(forward), 32'b0000);
    mem_rd = 5'd6; wb_rd = 5'd5; set_rs(5'd6, 5'd5); #1;
    check("fwd_mix", 32'(forward), 32'b1001);
    mem_reg_wr = 1'b0; wb_reg_wr = 1'b0; mem_rd = '0; wb_rd = '0; set_rs(5'd0, 5'd0);

    // Load-use
    issue(5'd7, 3'd1); #1;
    check("lu_issue_stall", 32'(stall), 32'h0);
    tick(); no_issue(); set_rs(5'd0, 5'd7); #1;
    check("lu_stall", 32'(stall), 32'h1);
    check("lu_busy", 32'(sb_busy), 32'h1);
    tick(); wb_rd = 5'd7; wb_reg_wr = 1'b1; #1;
    check("lu_release", 32'(stall), 32'h0);
    check("lu_fwd", 32'(forward[1:0]), 32'b01);
    wb_rd = '0; wb_reg_wr = 1'b0; set_rs(5'd0, 5'd0);

    // Multi-cycle with issues presented during the stall
    issue(5'd3, 3'd4);
    tick(); no_issue(); set_rs(5'd3, 5'd0); #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("mc_stall%0d", k), 32'(stall), 32'h1);
      check($sformatf("mc_busy%0d", k), 32'(sb_busy), 32'h1);
      if (k == 1) issue(5'd3, 3'd5);
      else if (k == 2) issue(5'd10, 3'd3);
      else no_issue();
      tick();
    end
    no_issue(); #1;
    check("mc_release", 32'(stall), 32'h0);
    check("mc_idle", 32'(sb_busy), 32'h0);
    set_rs(5'd0, 5'd0);

    // WAW: newer shorter issue wins
    issue(5'd3, 3'd4);
    tick(); no_issue();
    tick(); issue(5'd3, 3'd1);
    tick(); no_issue(); set_rs(5'd0, 5'd3); #1;
    check("waw_stall", 32'(stall), 32'h1);
    tick();
    check("waw_release", 32'(stall), 32'h0);
    check("waw_idle", 32'(sb_busy), 32'h0);
    set_rs(5'd0, 5'd0);

    // WAW on the edge where the old counter would reach zero
    issue(5'd4, 3'd1);
    tick(); issue(5'd4, 3'd2);
    tick(); no_issue(); set_rs(5'd4, 5'd0); #1;
    check("waw0_stall_a", 32'(stall), 32'h1);
    tick();
    check("waw0_stall_b", 32'(stall), 32'h1);
    tick();
    check("waw0_release", 32'(stall), 32'h0);
    set_rs(5'd0, 5'd0);

    // lat=0 issue leaves existing countdown alone
    issue(5'd8, 3'd3);
    tick(); issue(5'd8, 3'd0);
    tick(); no_issue(); set_rs(5'd0, 5'd8); #1;
    check("lat0_stall_a", 32'(stall), 32'h1);
    tick();
    check("lat0_stall_b", 32'(stall), 32'h1);
    tick();
    check("lat0_release", 32'(stall), 32'h0);
    set_rs(5'd0, 5'd0);

    // Saturation: lat 7 clamps to MAX_LAT=5
    issue(5'd6, 3'd7);
    tick(); no_issue(); set_rs(5'd6, 5'd0); #1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("sat_stall%0d", k), 32'(stall), 32'h1);
      tick();
    end
    check("sat_release", 32'(stall), 32'h0);
    set_rs(5'd0, 5'd0);

    // Register 0 is never tracked
    issue(5'd0, 3'd5);
    tick(); no_issue(); #1;
    check("r0_busy", 32'(sb_busy), 32'h0);
    check("r0_stall", 32'(stall), 32'h0);

    // Async reset mid-countdown
    issue(5'd9, 3'd6);
    tick(); no_issue();
    tick(); tick(); set_rs(5'd9, 5'd0); #1;
    check("rstmid_pre", 32'(stall), 32'h1);
    #2 rst_n = 1'b0; #1;
    check("rstmid_stall", 32'(stall), 32'h0);
    check("rstmid_busy", 32'(sb_busy), 32'h0);
`ifdef HAZARD_STALL_CNT_EN
    check("rstmid_scnt", stall_cycles, 32'h0);
`endif
    @(negedge clk) rst_n = 1'b1;
    tick();
    check("post_rst_stall", 32'(stall), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
